systolic_array_nxn: RTL and testbench

Parametrised N×N output-stationary signed systolic matrix-multiply engine: the next generation of the team's fixed 2×2 array. It computes C = A·B for A (N×K) and B (K×N) with K programmable per job. Unlike the 2×2 array, it contains its own input skew registers, a job-control FSM with valid/ready handshakes on both operand input and result output, and signed ReLU. It sits between the operand buffers (upstream) and the result writeback (downstream).

---
 rtl/tpu_pkg.sv | 20 ++
 rtl/pe_mac_signed.sv | 33 +++
 rtl/systolic_array_nxn.sv | 186 ++++++++++++++++++
 tb/tb_systolic_array_nxn.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared types and constants for the systolic matrix-multiply engine.
// Job FSM encoding, default widths and drain length.
package tpu_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED,
    S_DRAIN,
    S_OUTPUT
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_ACC_W = 24;

  // Cycles for the last injected beat to reach PE(N-1,N-1).
  function automatic int drain_len(input int n);
    return 2 * n - 1;
  endfunction

endpackage

// File: rtl/pe_mac_signed.sv
// Signed multiply-accumulate PE for an output-stationary array.
// Operands pass right/down through registers; acc wraps modulo 2^ACC_W.
module pe_mac_signed #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic signed [WIDTH-1:0] a_in,
  input  logic signed [WIDTH-1:0] b_in,
  output logic signed [WIDTH-1:0] a_out,
  output logic signed [WIDTH-1:0] b_out,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [2*WIDTH-1:0] prod;

  assign prod = a_in * b_in;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else begin
      a_out <= a_in;
      b_out <= b_in;
      acc   <= acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/systolic_array_nxn.sv
// N x N output-stationary signed systolic matrix multiplier.
// Holds input skew, job FSM, counters and ReLU output mux.
module systolic_array_nxn
  import tpu_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = DEF_WIDTH,
  parameter int ACC_W = DEF_ACC_W,
  parameter int KW    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [KW-1:0]        k_len,
  input  logic                 relu,
  output logic                 busy,
  output logic                 done,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WIDTH-1:0]   a_vec,
  input  logic [N*WIDTH-1:0]   b_vec,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*ACC_W-1:0]   out_row,
  output logic [$clog2(N)-1:0] out_row_idx
);

  localparam int IW = $clog2(N);
  localparam int DL = drain_len(N);
  localparam int DW = $clog2(DL + 1);

  state_t state, state_nx;

  logic [KW-1:0] k_q;
  logic [KW-1:0] beat_cnt;
  logic [DW-1:0] drain_cnt;
  logic [IW-1:0] row_idx;
  logic          relu_q;
  logic          done_q;

  logic accept;
  logic beat;
  logic last_row;

  assign accept    = (state == S_IDLE) && start;
  assign in_ready  = (state == S_FEED);
  assign beat      = in_valid && in_ready;
  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_OUTPUT);
  assign last_row  = (row_idx == IW'(N - 1));
  assign done      = done_q;

  assign out_row_idx = row_idx;

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (start)
          state_nx = (k_len == '0) ? S_OUTPUT : S_FEED;
      end
      S_FEED: begin
        if (beat && beat_cnt == k_q - KW'(1))
          state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_cnt == DW'(DL - 1))
          state_nx = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (out_ready && last_row)
          state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      k_q       <= '0;
      relu_q    <= 1'b0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
      row_idx   <= '0;
      done_q    <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= out_valid && out_ready && last_row;
      if (accept) begin
        k_q       <= k_len;
        relu_q    <= relu;
        beat_cnt  <= '0;
        drain_cnt <= '0;
        row_idx   <= '0;
      end
      if (beat)
        beat_cnt <= beat_cnt + KW'(1);
      if (state == S_DRAIN)
        drain_cnt <= drain_cnt + DW'(1);
      if (out_valid && out_ready)
        row_idx <= last_row ? '0 : row_idx + IW'(1);
    end
  end

  logic signed [WIDTH-1:0] inj_a [N];
  logic signed [WIDTH-1:0] inj_b [N];

  // Non-beat cycles inject zeros so bubbles add nothing.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      inj_a[i] = '0;
      inj_b[i] = '0;
      if (beat) begin
        inj_a[i] = a_vec[i*WIDTH +: WIDTH];
        inj_b[i] = b_vec[i*WIDTH +: WIDTH];
      end
    end
  end

  logic signed [WIDTH-1:0] a_h [N][N+1];
  logic signed [WIDTH-1:0] b_v [N+1][N];
  logic signed [ACC_W-1:0] acc [N][N];

  for (genvar gi = 0; gi < N; gi++) begin : g_skew
    if (gi == 0) begin : g_direct
      assign a_h[0][0] = inj_a[0];
      assign b_v[0][0] = inj_b[0];
    end else begin : g_sr
      logic signed [WIDTH-1:0] sa [gi];
      logic signed [WIDTH-1:0] sb [gi];

      always_ff @(posedge clk) begin
        if (rst || accept) begin
          for (int s = 0; s < gi; s++) begin
            sa[s] <= '0;
            sb[s] <= '0;
          end
        end else begin
          sa[0] <= inj_a[gi];
          sb[0] <= inj_b[gi];
          for (int s = 1; s < gi; s++) begin
            sa[s] <= sa[s-1];
            sb[s] <= sb[s-1];
          end
        end
      end

      assign a_h[gi][0] = sa[gi-1];
      assign b_v[0][gi] = sb[gi-1];
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      pe_mac_signed #(
        .WIDTH(WIDTH),
        .ACC_W(ACC_W)
      ) u_pe (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .a_in (a_h[gi][gj]),
        .b_in (b_v[gi][gj]),
        .a_out(a_h[gi][gj+1]),
        .b_out(b_v[gi+1][gj]),
        .acc  (acc[gi][gj])
      );
    end
  end

  logic signed [ACC_W-1:0] row_sel [N];

  // ReLU only masks the output view; accumulators stay intact.
  always_comb begin
    out_row = '0;
    for (int j = 0; j < N; j++) begin
      row_sel[j] = acc[row_idx][j];
      if (relu_q && row_sel[j][ACC_W-1])
        row_sel[j] = '0;
      if (out_valid)
        out_row[j*ACC_W +: ACC_W] = row_sel[j];
    end
  end

endmodule

// File: tb/tb_systolic_array_nxn.sv
// Randomized bench for systolic_array_nxn against a matrix model.
// Two instances: N=2/ACC_W=16 and N=4/ACC_W=24.
module tb_systolic_array_nxn;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start;
  logic [7:0] k_len;
  logic       relu;
  logic       in_valid;
  logic       out_ready;
  int         sel;

  logic        st2, st4;
  logic [15:0] a2, b2;
  logic [31:0] a4, b4;
  logic        busy2, done2, ir2, ov2;
  logic        busy4, done4, ir4, ov4;
  logic [31:0] row2;
  logic [95:0] row4;
  logic [0:0]  idx2;
  logic [1:0]  idx4;

  assign st2 = start && (sel == 0);
  assign st4 = start && (sel == 1);

  systolic_array_nxn #(
    .N(2), .WIDTH(8), .ACC_W(16), .KW(8)
  ) u_dut2 (
    .clk(clk), .rst(rst), .start(st2),
    .k_len(k_len), .relu(relu),
    .busy(busy2), .done(done2),
    .in_valid(in_valid), .in_ready(ir2),
    .a_vec(a2), .b_vec(b2),
    .out_valid(ov2), .out_ready(out_ready),
    .out_row(row2), .out_row_idx(idx2)
  );

  systolic_array_nxn #(
    .N(4), .WIDTH(8), .ACC_W(24), .KW(8)
  ) u_dut4 (
    .clk(clk), .rst(rst), .start(st4),
    .k_len(k_len), .relu(relu),
    .busy(busy4), .done(done4),
    .in_valid(in_valid), .in_ready(ir4),
    .a_vec(a4), .b_vec(b4),
    .out_valid(ov4), .out_ready(out_ready),
    .out_row(row4), .out_row_idx(idx4)
  );

  logic   o_busy, o_done, o_ir, o_ov;
  int     o_idx;
  longint o_row [4];

  always_comb begin
    o_busy = busy4;
    o_done = done4;
    o_ir   = ir4;
    o_ov   = ov4;
    o_idx  = int'(idx4);
    for (int j = 0; j < 4; j++)
      o_row[j] = longint'($signed(row4[j*24 +: 24]));
    if (sel == 0) begin
      o_busy = busy2;
      o_done = done2;
      o_ir   = ir2;
      o_ov   = ov2;
      o_idx  = int'(idx2);
      for (int j = 0; j < 4; j++)
        o_row[j] = (j < 2) ? longint'($signed(row2[j*16 +: 16])) : 0;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input longint got,
                       input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int     A [4][16];
  int     B [16][4];
  longint expm [4][4];

  // C = A*B, reduced to ACC_W bits two's complement, then ReLU.
  task automatic compute_exp(input int k, input bit rl);
    int     nn, w;
    longint m, s;
    nn = (sel == 0) ? 2 : 4;
    w  = (sel == 0) ? 16 : 24;
    m  = longint'(1) << w;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        s = 0;
        for (int kk = 0; kk < k; kk++)
          s += longint'(A[i][kk]) * longint'(B[kk][j]);
        s = s & (m - 1);
        if (s >= (m >> 1)) s -= m;
        if (rl && s < 0) s = 0;
        expm[i][j] = (i < nn && j < nn) ? s : 0;
      end
  endtask

  task automatic set_ops(input int k, input bit valid);
    for (int i = 0; i < 4; i++) begin
      if (valid) begin
        a4[i*8 +: 8] = 8'(A[i][k]);
        b4[i*8 +: 8] = 8'(B[k][i]);
      end else begin
        a4[i*8 +: 8] = 8'($urandom);
        b4[i*8 +: 8] = 8'($urandom);
      end
      if (i < 2) begin
        a2[i*8 +: 8] = a4[i*8 +: 8];
        b2[i*8 +: 8] = b4[i*8 +: 8];
      end
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 16; k++) begin
        A[i][k] = int'($urandom_range(0, 255)) - 128;
        B[k][i] = int'($urandom_range(0, 255)) - 128;
      end
  endtask

  task automatic run_job(input int k, input bit rl,
                         input bit bub, input bit stall);
    int nn, s, last, beats, guard, r, stalls, lat;
    nn = (sel == 0) ? 2 : 4;
    compute_exp(k, rl);
    @(negedge clk);
    start = 1'b1;
    k_len = 8'(k);
    relu  = rl;
    s     = cyc;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", o_busy, 1);
    if (k > 0) check("feed_ready", o_ir, 1);
    beats = 0;
    guard = 0;
    last  = s;
    while (beats < k && guard < 2000) begin
      in_valid = bub ? ($urandom_range(0, 2) != 0) : 1'b1;
      set_ops(beats, in_valid);
      #1;
      if (in_valid && o_ir) begin
        beats++;
        last = cyc;
      end
      @(negedge clk);
      guard++;
    end
    if (beats < k) check("feed_timeout", beats, k);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    guard = 0;
    while (!o_ov && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("first_valid_cyc", cyc, (k == 0) ? s + 1 : last + 2 * nn);
    r = 0;
    stalls = 0;
    guard = 0;
    while (r < nn && guard < 400) begin
      start = 1'b0;
      if (stall && r == 1 && stalls < 5) begin
        out_ready = 1'b0;
        stalls++;
        if (stalls == 2) start = 1'b1;
      end else begin
        out_ready = bub ? ($urandom_range(0, 1) != 0) : 1'b1;
      end
      #1;
      if (o_ov && out_ready) begin
        check("row_idx", o_idx, r);
        for (int j = 0; j < nn; j++)
          check($sformatf("c%0d%0d", r, j), o_row[j], expm[r][j]);
        r++;
      end else if (stall && r == 1) begin
        check("stall_valid", o_ov, 1);
        check("stall_busy", o_busy, 1);
        check("stall_idx", o_idx, 1);
        for (int j = 0; j < nn; j++)
          check("stall_row", o_row[j], expm[1][j]);
      end
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
    if (r < nn) check("out_timeout", r, nn);
    check("done_pulse", o_done, 1);
    check("idle_after", o_busy, 0);
    if (!bub && !stall) begin
      lat = (k > 0) ? 1 + k + (2 * nn - 1) + nn : 1 + nn;
      check("done_latency", cyc - s, lat);
    end
    @(negedge clk);
    check("done_one_cycle", o_done, 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    k_len = '0;
    relu = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a2 = '0; b2 = '0; a4 = '0; b4 = '0;
    sel = 0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      sel = d;
      #1;
      check("rst_busy", o_busy, 0);
      check("rst_done", o_done, 0);
      check("rst_in_ready", o_ir, 0);
      check("rst_out_valid", o_ov, 0);
      check("rst_idx", o_idx, 0);
      for (int j = 0; j < 4; j++)
        check("rst_row", o_row[j], 0);
    end
    rst = 1'b0;

    // N=2 worked example.
    sel = 0;
    A[0][0] = 1; A[0][1] = 2; A[1][0] = 3; A[1][1] = 4;
    B[0][0] = 5; B[0][1] = 6; B[1][0] = 7; B[1][1] = 8;
    run_job(2, 0, 0, 0);

    // Signed operands with and without ReLU.
    A[0][0] = -3; A[1][0] = 2;
    B[0][0] = 4;  B[0][1] = 5;
    run_job(1, 0, 0, 0);
    run_job(1, 1, 0, 0);

    // 16-bit wrap: 3 * 16384 -> -16384.
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 3; k++) begin
        A[i][k] = -128;
        B[k][i] = -128;
      end
    run_job(3, 0, 0, 0);
    run_job(0, 0, 0, 0);

    // N=4 identity times B.
    sel = 1;
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        A[i][k] = (i == k) ? 1 : 0;
        B[k][i] = k * 4 + i + 1;
      end
    run_job(4, 0, 0, 0);
    run_job(4, 0, 1, 0);

    rand_ops();
    run_job(5, 0, 0, 1);

    // Abort mid-FEED, then verify a clean job.
    rand_ops();
    @(negedge clk);
    start = 1'b1;
    k_len = 8'd6;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    set_ops(0, 1'b1);
    @(negedge clk);
    set_ops(1, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", o_busy, 0);
    check("abort_in_ready", o_ir, 0);
    rst = 1'b0;
    rand_ops();
    run_job(3, 0, 0, 0);
    run_job(0, 1, 0, 0);

    for (int t = 0; t < 6; t++) begin
      sel = t % 2;
      rand_ops();
      run_job(int'($urandom_range(1, 12)), 1'($urandom),
              1'($urandom), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
